// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write, one quotient bit per cycle.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quot_step;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;

  // Compare/subtract in WIDTH+1 bits so the shifted-out MSB is never lost.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dsr_q};
  assign q_bit     = (rem_shift >= {1'b0, dsr_q});
  assign rem_step  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quot_step = {dvd_q[WIDTH-2:0], q_bit};

  assign op1_abs = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign op2_abs = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = ready_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start && !annul) begin
          if (opdata2 == '0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d = ST_ON;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = op1_abs;
            dsr_d   = op2_abs;
            qneg_d  = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            rneg_d  = signed_div & opdata1[WIDTH-1];
          end
        end
      end
      ST_BYZERO: begin
        if (annul) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ST_ON: begin
        if (annul) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_step;
          dvd_d = quot_step;
          if (cnt_q == CNT_LAST) begin
            // Final step: fold the sign fix-up into the result register.
            state_d  = ST_END;
            cnt_d    = '0;
            ready_d  = 1'b1;
            result_d = {(rneg_q ? -rem_step : rem_step),
                        (qneg_q ? -quot_step : quot_step)};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_END: begin
        if (annul || !start) begin
          state_d  = ST_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign ready     = ready_q;
  assign stall_req = start & ~ready_q & ~annul;

endmodule
